// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side character buffer between the UART receiver and the bus.
// A DEPTH-entry circular FIFO that never back-pressures the receiver. Characters
// arriving while the FIFO is full are dropped, and the sticky ovf_o flag records it.
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to build the idle-timeout
// counter behind tmo_o. Without it, tmo_o is tied 0 and cfg_timeout_i is ignored.
module uart_rx_fifo #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          clr_i,
  input  logic [7:0]    in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [7:0]    out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [LW-1:0] level_o,
  input  logic [LW-1:0] thresh_i,
  output logic          irq_thresh_o,
  output logic          ovf_o,
  input  logic          ovf_clr_i,
  input  logic [15:0]   cfg_timeout_i,
  output logic          tmo_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          rdy_q;
  logic          ovf_q, ovf_d;
  logic          full, push, pop, drop;

  assign full  = (cnt_q == LW'(DEPTH));
  assign pop   = out_valid_o & out_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push  = in_valid_i & in_ready_o & (~full | pop);
  assign drop  = in_valid_i & in_ready_o & full & ~pop;

  assign in_ready_o   = rdy_q;
  assign out_valid_o  = (cnt_q != '0);
  assign out_data_o   = out_valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign level_o      = cnt_q;
  assign irq_thresh_o = (thresh_i != '0) && (cnt_q >= thresh_i);
  assign ovf_o        = ovf_q;

  // Next-state for pointers, count and overflow flag; clr_i overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
      // Set wins over clear when a drop coincides with ovf_clr_i.
      if (drop)           ovf_d = 1'b1;
      else if (ovf_clr_i) ovf_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rdy_q    <= 1'b1;
    end
  end

  // Storage array write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push && !clr_i) mem_q[wr_ptr_q] <= in_data_i;
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;
  logic        tmo_q, tmo_d;

  // Idle counter restarts on any activity or when the FIFO is empty; saturates.
  always_comb begin
    idle_d = idle_q;
    tmo_d  = tmo_q;
    if (clr_i || push || pop || (cnt_q == '0)) idle_d = '0;
    else if (idle_q != 16'hFFFF)               idle_d = idle_q + 16'd1;
    if (clr_i || pop) tmo_d = 1'b0;
    else if ((cfg_timeout_i != 16'd0) && (idle_q == cfg_timeout_i)) tmo_d = 1'b1;
  end

  // Timeout state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idle_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      tmo_q  <= tmo_d;
    end
  end

  assign tmo_o = tmo_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^cfg_timeout_i;
  assign tmo_o      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with DEPTH=16. Follows the timeout-enable macro
// so the same bench covers both builds.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          clr_i;
  logic [7:0]    in_data_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [7:0]    out_data_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [LW-1:0] level_o;
  logic [LW-1:0] thresh_i;
  logic          irq_thresh_o;
  logic          ovf_o;
  logic          ovf_clr_i;
  logic [15:0]   cfg_timeout_i;
  logic          tmo_o;

  int checks   = 0;
  int failures = 0;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clr_i        (clr_i),
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .level_o      (level_o),
    .thresh_i     (thresh_i),
    .irq_thresh_o (irq_thresh_o),
    .ovf_o        (ovf_o),
    .ovf_clr_i    (ovf_clr_i),
    .cfg_timeout_i(cfg_timeout_i),
    .tmo_o        (tmo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    in_valid_i = 1'b1;
    in_data_i  = d;
    step();
    in_valid_i = 1'b0;
  endtask

  initial begin
    logic [7:0] exp3 [3];
    int n;
    exp3[0] = 8'hA1; exp3[1] = 8'hB2; exp3[2] = 8'hC3;

    rstn_i = 1'b0; clr_i = 1'b0; in_data_i = '0; in_valid_i = 1'b0;
    out_ready_i = 1'b0; thresh_i = '0; ovf_clr_i = 1'b0; cfg_timeout_i = '0;
    #12;
    check("rst_in_ready", in_ready_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_data", out_data_o, 8'h00);
    check("rst_level", level_o, 0);
    check("rst_irq", irq_thresh_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_tmo", tmo_o, 0);
    rstn_i = 1'b1;
    step();
    check("in_ready_after_rst", in_ready_o, 1);

    // Three characters in, then drained in order.
    for (int i = 0; i < 3; i++) push_byte(exp3[i]);
    check("t1_level", level_o, 3);
    check("t1_head", out_data_o, 8'hA1);
    check("t1_valid", out_valid_o, 1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t1_pop_data", out_data_o, exp3[i]);
      step();
    end
    out_ready_i = 1'b0;
    check("t1_empty_valid", out_valid_o, 0);
    check("t1_empty_data", out_data_o, 8'h00);
    check("t1_empty_level", level_o, 0);

    // Overflow: 17 pushes into 16 slots.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("t2_full_level", level_o, 16);
    check("t2_no_ovf_yet", ovf_o, 0);
    push_byte(8'h10);
    check("t2_level_after_drop", level_o, 16);
    check("t2_ovf_set", ovf_o, 1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_pop_data", out_data_o, 32'(i));
      step();
    end
    out_ready_i = 1'b0;
    check("t2_drained", level_o, 0);
    check("t2_ovf_sticky", ovf_o, 1);
    ovf_clr_i = 1'b1;
    step();
    ovf_clr_i = 1'b0;
    check("t2_ovf_cleared", ovf_o, 0);

    // Simultaneous push and pop on a full FIFO.
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    check("t3_full", level_o, 16);
    in_valid_i = 1'b1; in_data_i = 8'h55; out_ready_i = 1'b1;
    check("t3_head", out_data_o, 8'h20);
    step();
    in_valid_i = 1'b0;
    check("t3_level_held", level_o, 16);
    check("t3_no_ovf", ovf_o, 0);
    for (int i = 1; i < 16; i++) begin
      check("t3_pop_data", out_data_o, 32'h20 + 32'(i));
      step();
    end
    check("t3_last_byte", out_data_o, 8'h55);
    step();
    out_ready_i = 1'b0;
    check("t3_empty", out_valid_o, 0);

    // Threshold interrupt.
    thresh_i = LW'(4);
    for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i));
    check("t4_irq_below", irq_thresh_o, 0);
    push_byte(8'h33);
    check("t4_irq_at", irq_thresh_o, 1);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("t4_level3", level_o, 3);
    check("t4_irq_fall", irq_thresh_o, 0);
    push_byte(8'h34);
    thresh_i = '0;
    #1;
    check("t4_irq_disabled", irq_thresh_o, 0);

    // Flush at level 5 with a concurrent push.
    push_byte(8'h35);
    check("t5_level5", level_o, 5);
    clr_i = 1'b1; in_valid_i = 1'b1; in_data_i = 8'h77;
    step();
    clr_i = 1'b0; in_valid_i = 1'b0;
    check("t5_clr_level", level_o, 0);
    check("t5_clr_valid", out_valid_o, 0);
    check("t5_clr_ovf", ovf_o, 0);
    check("t5_clr_tmo", tmo_o, 0);

    // Flush also clears a set overflow flag.
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    check("t5_ovf_set", ovf_o, 1);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check("t5_ovf_flushed", ovf_o, 0);
    check("t5_level_flushed", level_o, 0);

    // Idle timeout.
    cfg_timeout_i = 16'd10;
    push_byte(8'h99);
    n = 0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    while (!tmo_o && n < 20) begin
      step();
      n++;
    end
    check("t6_tmo_set", tmo_o, 1);
    check("t6_tmo_latency_ok", 32'(n <= 11), 1);
`else
    while (n < 20) begin
      step();
      n++;
    end
    check("t6_tmo_off", tmo_o, 0);
`endif
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("t6_tmo_after_pop", tmo_o, 0);
    check("t6_empty", level_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
